// File: rtl/soc_mgmt_pll_seq.sv
// PLL bring-up and clock-mux switch-over sequencer on the always-on reference clock.
// Resets the PLL, qualifies lock, hands the consumer mux to the PLL and falls back safely.
module soc_mgmt_pll_seq #(
    parameter int SyncStages       = 3,
    parameter int ResetHoldCycles  = 32,
    parameter int LockStableCycles = 8,
    parameter int TimeoutW         = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable_req,
    input  logic                i_disable_req,
    input  logic                i_clear,
    input  logic [TimeoutW-1:0] i_timeout,
    input  logic                i_pll_lock,
    input  logic                i_mux_active,
    output logic                o_pll_resetb,
    output logic                o_mux_select,
    output logic                o_busy,
    output logic                o_running,
    output logic                o_err_timeout,
    output logic                o_err_lock_lost,
    output logic [2:0]          o_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        WAIT_LOCK = 3'd2,
        SW_PLL    = 3'd3,
        RUN       = 3'd4,
        SW_REF    = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam int CntMax = (ResetHoldCycles > LockStableCycles) ? ResetHoldCycles : LockStableCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(ResetHoldCycles - 1);
    localparam logic [CntW-1:0] StableLast = CntW'(LockStableCycles - 1);

    state_t              state_reg, state_next;
    logic [SyncStages-1:0] sync_reg, sync_next;
    logic [CntW-1:0]     cnt_reg, cnt_next;
    logic [TimeoutW-1:0] tmo_reg, tmo_next, tmo_inc;
    logic                err_tmo_reg, err_tmo_next;
    logic                err_lost_reg, err_lost_next;
    logic                resetb_reg, resetb_next;
    logic                select_reg, select_next;
    logic                busy_reg, busy_next;
    logic                running_reg, running_next;
    logic                lock_s, timeout_hit, set_tmo, set_lost;

    generate
        for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = i_pll_lock;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign lock_s = sync_reg[SyncStages-1];

    // Time-in-state counter; saturates so a long RUN never wraps into a false timeout.
    assign tmo_inc     = (&tmo_reg) ? tmo_reg : tmo_reg + TimeoutW'(1);
    assign timeout_hit = (i_timeout != '0) && (tmo_inc == i_timeout);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_inc;
        set_tmo    = 1'b0;
        set_lost   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_enable_req) state_next = RST_HOLD;
            end
            RST_HOLD: begin
                if (i_disable_req)            state_next = IDLE;
                else if (cnt_reg == HoldLast) state_next = WAIT_LOCK;
                else                          cnt_next   = cnt_reg + CntW'(1);
            end
            WAIT_LOCK: begin
                cnt_next = lock_s ? cnt_reg + CntW'(1) : '0;
                if (i_disable_req) begin
                    state_next = IDLE;
                end else if (lock_s && (cnt_reg == StableLast)) begin
                    state_next = SW_PLL;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                    set_tmo    = 1'b1;
                end
            end
            SW_PLL: begin
                if (!lock_s) begin
                    state_next = SW_REF;
                    set_lost   = 1'b1;
                end else if (i_mux_active) begin
                    state_next = RUN;
                end else if (timeout_hit) begin
                    state_next = SW_REF;
                    set_tmo    = 1'b1;
                end
            end
            RUN: begin
                // Lock loss outranks a simultaneous disable so the flag is never lost.
                if (!lock_s) begin
                    state_next = SW_REF;
                    set_lost   = 1'b1;
                end else if (i_disable_req) begin
                    state_next = SW_REF;
                end
            end
            SW_REF: begin
                if (!i_mux_active) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                    set_tmo    = 1'b1;
                end
            end
            ERROR: begin
                if (i_clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
            tmo_next = '0;
        end

        err_tmo_next  = set_tmo  | (err_tmo_reg  & ~i_clear);
        err_lost_next = set_lost | (err_lost_reg & ~i_clear);

        // Outputs decoded from the next state so they register alongside it.
        resetb_next  = state_next inside {WAIT_LOCK, SW_PLL, RUN, SW_REF};
        select_next  = (state_next == SW_PLL) || (state_next == RUN);
        busy_next    = state_next inside {RST_HOLD, WAIT_LOCK, SW_PLL, SW_REF};
        running_next = (state_next == RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            sync_reg     <= '0;
            cnt_reg      <= '0;
            tmo_reg      <= '0;
            err_tmo_reg  <= 1'b0;
            err_lost_reg <= 1'b0;
            resetb_reg   <= 1'b0;
            select_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sync_reg     <= sync_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            err_tmo_reg  <= err_tmo_next;
            err_lost_reg <= err_lost_next;
            resetb_reg   <= resetb_next;
            select_reg   <= select_next;
            busy_reg     <= busy_next;
            running_reg  <= running_next;
        end
    end

    assign o_state         = state_reg;
    assign o_pll_resetb    = resetb_reg;
    assign o_mux_select    = select_reg;
    assign o_busy          = busy_reg;
    assign o_running       = running_reg;
    assign o_err_timeout   = err_tmo_reg;
    assign o_err_lock_lost = err_lost_reg;

endmodule

// File: tb/tb_soc_mgmt_pll_seq.sv
// Bench for soc_mgmt_pll_seq: directed sequences, a scenario table and random traffic,
// all checked cycle by cycle against an elapsed-time reference model.
module tb_soc_mgmt_pll_seq;
    localparam int SyncStages = 3;
    localparam int ResetHold  = 32;
    localparam int LockStable = 8;

    logic        clk = 1'b0;
    logic        rst_n, enable_req, disable_req, clear, pll_lock, mux_active;
    logic [15:0] timeout;
    logic        pll_resetb, mux_select, busy, running, err_timeout, err_lock_lost;
    logic [2:0]  state;

    always #5 clk = ~clk;

    soc_mgmt_pll_seq dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable_req   (enable_req),
        .i_disable_req  (disable_req),
        .i_clear        (clear),
        .i_timeout      (timeout),
        .i_pll_lock     (pll_lock),
        .i_mux_active   (mux_active),
        .o_pll_resetb   (pll_resetb),
        .o_mux_select   (mux_select),
        .o_busy         (busy),
        .o_running      (running),
        .o_err_timeout  (err_timeout),
        .o_err_lock_lost(err_lock_lost),
        .o_state        (state)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase code, cycles spent in phase, consecutive lock-high count.
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_run     = 0;
    bit m_errt    = 1'b0;
    bit m_errl    = 1'b0;
    bit m_q[$];

    // Mux emulation: active follows select after a programmable delay, drops 2 cycles after.
    int   mux_on_delay = 5;
    int   sel_age      = 0;
    logic sel_last     = 1'b0;

    typedef struct {
        int lock_delay;
        int mux_delay;
        int tmo;
        int exp_state;
        int exp_errt;
        int exp_errl;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {23'd0, state, pll_resetb, mux_select, busy, running, err_timeout, err_lock_lost};
    endfunction

    function automatic logic [31:0] model_vec();
        logic rb, sel, bsy, rn;
        rb  = (m_phase >= 2) && (m_phase <= 5);
        sel = (m_phase == 3) || (m_phase == 4);
        bsy = (m_phase == 1) || (m_phase == 2) || (m_phase == 3) || (m_phase == 5);
        rn  = (m_phase == 4);
        return {23'd0, 3'(m_phase), rb, sel, bsy, rn, m_errt, m_errl};
    endfunction

    task automatic model_edge();
        bit ls, to_hit, st, sl;
        int el, nxt, nrun;
        if (rst_n !== 1'b1) begin
            m_phase = 0; m_elapsed = 0; m_run = 0; m_errt = 1'b0; m_errl = 1'b0;
            m_q.delete();
            repeat (SyncStages) m_q.push_back(1'b0);
            return;
        end
        ls = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(pll_lock);
        el = m_elapsed + 1;
        if (el > 65535) el = 65535;
        to_hit = (timeout != 16'd0) && (el == int'(timeout));
        nxt = m_phase; nrun = m_run; st = 1'b0; sl = 1'b0;
        case (m_phase)
            0: if (enable_req) nxt = 1;
            1: if (disable_req) nxt = 0; else if (el == ResetHold) nxt = 2;
            2: begin
                nrun = ls ? m_run + 1 : 0;
                if (disable_req) nxt = 0;
                else if (nrun == LockStable) nxt = 3;
                else if (to_hit) begin nxt = 6; st = 1'b1; end
            end
            3: if (!ls) begin nxt = 5; sl = 1'b1; end
               else if (mux_active) nxt = 4;
               else if (to_hit) begin nxt = 5; st = 1'b1; end
            4: if (!ls) begin nxt = 5; sl = 1'b1; end else if (disable_req) nxt = 5;
            5: if (!mux_active) nxt = 0; else if (to_hit) begin nxt = 6; st = 1'b1; end
            default: if (clear) nxt = 0;
        endcase
        m_errt = st | (m_errt & !clear);
        m_errl = sl | (m_errl & !clear);
        if (nxt != m_phase) begin
            m_phase = nxt; m_elapsed = 0; m_run = 0;
        end else begin
            m_elapsed = el; m_run = nrun;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_vec(), model_vec());
        enable_req  = 1'b0;
        disable_req = 1'b0;
        clear       = 1'b0;
        if (mux_select === sel_last) sel_age++;
        else begin sel_age = 0; sel_last = mux_select; end
        if (mux_select === 1'b1) begin
            if (mux_on_delay >= 0 && sel_age >= mux_on_delay) mux_active = 1'b1;
        end else if (sel_age >= 2) begin
            mux_active = 1'b0;
        end
    endtask

    function automatic bit cond(input int what);
        case (what)
            0: return pll_resetb === 1'b1;
            1: return state === 3'd3;
            2: return state === 3'd6;
            3: return running === 1'b1;
            5: return state === 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int what, input string name, output int n);
        n = 0;
        while (!cond(what)) begin
            if (n >= 400) begin
                checks++;
                failures++;
                $display("FAIL %s wait expired after %0d cycles", name, n);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        pll_lock = 1'b0;
        mux_active = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic bring_up(input int lock_delay, input int mux_delay);
        int n;
        mux_on_delay = mux_delay;
        pll_lock = 1'b0;
        enable_req = 1'b1;
        step();
        wait_until(0, "resetb_rise", n);
        repeat (lock_delay) step();
        pll_lock = 1'b1;
        wait_until(3, "running", n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit sel_seen;
        rst_n = 1'b0; enable_req = 1'b0; disable_req = 1'b0; clear = 1'b0;
        pll_lock = 1'b0; mux_active = 1'b0; timeout = 16'd0;
        repeat (SyncStages) m_q.push_back(1'b0);

        // Nominal bring-up
        do_reset();
        check("reset_state", dut_vec(), 32'd0);
        mux_on_delay = 5;
        enable_req = 1'b1;
        step();
        check("busy_after_req", 32'(busy), 32'd1);
        wait_until(0, "resetb_rise", n);
        check("resetb_low_cycles", n, 32);
        repeat (10) step();
        pll_lock = 1'b1;
        wait_until(1, "sw_pll", n);
        check("lock_to_sw_pll", n, 11);
        wait_until(3, "running", n);
        check("nominal_running", 32'(running), 32'd1);
        check("nominal_flags", {30'd0, err_timeout, err_lock_lost}, 32'd0);
        $display("seq nominal: state=%0d resetb=%0d select=%0d", state, pll_resetb, mux_select);

        // Lock glitch restarts the stable count
        do_reset();
        enable_req = 1'b1;
        step();
        wait_until(0, "resetb_rise", n);
        pll_lock = 1'b1;
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_until(1, "glitch_sw_pll", n);
        check("glitch_to_sw_pll", n, 11);
        wait_until(3, "glitch_running", n);
        $display("seq glitch: sw_pll after %0d cycles", n);

        // Lock loss coinciding with disable while running
        pll_lock = 1'b0;
        repeat (3) step();
        check("select_held", 32'(mux_select), 32'd1);
        disable_req = 1'b1;
        step();
        check("select_fall", 32'(mux_select), 32'd0);
        check("err_lock_lost", 32'(err_lock_lost), 32'd1);
        wait_until(5, "idle_after_loss", n);
        check("idle_after_loss", 32'(state), 32'd0);
        check("resetb_after_loss", 32'(pll_resetb), 32'd0);
        $display("seq lock_loss: state=%0d err_lock_lost=%0d", state, err_lock_lost);

        // Lock timeout into ERROR, then clear
        do_reset();
        timeout = 16'd100;
        enable_req = 1'b1;
        step();
        wait_until(0, "tmo_resetb", n);
        wait_until(2, "tmo_error", n);
        check("timeout_cycles", n, 100);
        check("err_timeout_set", 32'(err_timeout), 32'd1);
        check("error_resetb", 32'(pll_resetb), 32'd0);
        clear = 1'b1;
        step();
        check("clear_state", 32'(state), 32'd0);
        check("clear_flag", 32'(err_timeout), 32'd0);
        timeout = 16'd0;
        $display("seq timeout: error after %0d cycles", n);

        // Disable while waiting for lock
        do_reset();
        enable_req = 1'b1;
        step();
        wait_until(0, "dis_resetb", n);
        pll_lock = 1'b1;
        repeat (5) step();
        disable_req = 1'b1;
        step();
        check("disable_idle", 32'(state), 32'd0);
        check("disable_resetb", 32'(pll_resetb), 32'd0);
        sel_seen = 1'b0;
        repeat (20) begin
            step();
            if (mux_select === 1'b1) sel_seen = 1'b1;
        end
        check("disable_no_select", 32'(sel_seen), 32'd0);
        $display("seq disable_wait: state=%0d", state);

        // Synchronous reset from RUN, then a fresh bring-up
        do_reset();
        bring_up(10, 5);
        rst_n = 1'b0;
        step();
        check("reset_in_run", dut_vec(), 32'd0);
        rst_n = 1'b1;
        bring_up(10, 5);
        check("rerun_running", 32'(running), 32'd1);
        $display("seq reset_in_run: running=%0d", running);

        // Scenario table
        vecs[0] = '{10,  5,   0, 4, 0, 0};
        vecs[1] = '{-1,  5, 100, 6, 1, 0};
        vecs[2] = '{10, -1,  50, 0, 1, 0};
        vecs[3] = '{ 3,  2,  60, 4, 0, 0};
        vecs[4] = '{-1,  0,   1, 6, 1, 0};
        vecs[5] = '{ 0,  0,  20, 4, 0, 0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            timeout = 16'(vecs[i].tmo);
            mux_on_delay = vecs[i].mux_delay;
            enable_req = 1'b1;
            step();
            wait_until(0, "vec_resetb", n);
            if (vecs[i].lock_delay >= 0) begin
                repeat (vecs[i].lock_delay) step();
                pll_lock = 1'b1;
            end
            repeat (200) step();
            check("vec_state", 32'(state), vecs[i].exp_state);
            check("vec_err_timeout", 32'(err_timeout), vecs[i].exp_errt);
            check("vec_err_lock_lost", 32'(err_lock_lost), vecs[i].exp_errl);
            $display("vec %0d: state=%0d err_timeout=%0d err_lock_lost=%0d",
                     i, state, err_timeout, err_lock_lost);
        end

        // Random traffic against the model
        do_reset();
        timeout = 16'd0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       timeout = 16'd0;
                    1:       timeout = 16'd30;
                    default: timeout = 16'd150;
                endcase
            end
            if (c % 300 == 0) begin
                if ($urandom_range(0, 7) == 7) mux_on_delay = -1;
                else mux_on_delay = int'($urandom_range(0, 6));
            end
            rst_n       = ($urandom_range(0, 799) != 0);
            enable_req  = ($urandom_range(0, 24) == 0);
            disable_req = ($urandom_range(0, 149) == 0);
            clear       = ($urandom_range(0, 99) == 0);
            if (pll_lock) begin
                if ($urandom_range(0, 119) == 0) pll_lock = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                pll_lock = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) mux_active = ~mux_active;
            step();
        end
        rst_n = 1'b1;
        $display("random: done state=%0d", state);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
